// File: rtl/mem_1r1w_banked_if.sv
// Read/write port bundle for mem_1r1w_banked: one read port (R0), one
// write port (W0) and the sticky out-of-range flag.
interface mem_1r1w_banked_if #(
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 64,
  parameter int NLANES = 4
);
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [WIDTH-1:0]  R0_data;
  logic              R0_valid;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [WIDTH-1:0]  W0_data;
  logic [NLANES-1:0] W0_mask;
  logic              oor_flag;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_data, R0_valid, oor_flag
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_data, R0_valid, oor_flag
  );
endinterface

// File: rtl/mem_1r1w_banked.sv
// Banked 1r1w memory: tiles two-port register-file macros into banks (depth)
// and slices (width), adding lane write masks, write-first collision
// forwarding, a held read-data output, a read-valid strobe and a sticky
// out-of-range flag.

// Behavioural two-port register-file macro with active-low chip enables,
// per-bit write mask and a registered read port that returns old data on a
// same-address read/write.
module rf_2p_macro #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rd_ce_n,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_q,
  input  logic          wr_ce_n,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [DW-1:0] wr_bmask
);
  logic [DW-1:0] mem [2**AW];

  // Masked write into the storage array.
  // NOTE: storage arrays carry no reset; clearing them would turn the array
  // into thousands of resettable flops instead of a RAM.
  always_ff @(posedge clk) begin
    if (!wr_ce_n) mem[wr_addr] <= (mem[wr_addr] & ~wr_bmask) | (wr_data & wr_bmask);
  end

  // Registered read; sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rd_ce_n) rd_q <= mem[rd_addr];
  end
endmodule

module mem_1r1w_banked #(
  parameter int DEPTH       = 48,
  parameter int WIDTH       = 64,
  parameter int BANK_DEPTH  = 32,
  parameter int MACRO_WIDTH = 16,
  parameter int MASK_GRAN   = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int NLANES      = WIDTH / MASK_GRAN
) (
  input logic              clk,
  input logic              rst_n,
  mem_1r1w_banked_if.slave bus
);
  localparam int BANK_AW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int NBANKS  = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int NSLICES = (WIDTH + MACRO_WIDTH - 1) / MACRO_WIDTH;
  localparam int PADW    = NSLICES * MACRO_WIDTH;
  localparam int BIDX_W  = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              r_inr, w_inr, collide;
  logic [ADDR_W-1:0] r_bank_a, w_bank_a;
  logic [BANK_AW-1:0] r_maddr, w_maddr;
  logic [WIDTH-1:0]  w_bmask;
  logic [PADW-1:0]   w_bmask_pad, w_data_pad;
  logic [MACRO_WIDTH-1:0] macro_q [NBANKS][NSLICES];
  logic [PADW-1:0]   rd_sel;
  logic [WIDTH-1:0]  rd_merged;

  logic              rd_pend_q;
  logic [BIDX_W-1:0] r_bank_q;
  logic              r_inr_q;
  logic [WIDTH-1:0]  fwd_data_q, fwd_mask_q, data_hold_q;
  logic              oor_q;

  assign r_inr    = {1'b0, bus.R0_addr} < DEPTH_L;
  assign w_inr    = {1'b0, bus.W0_addr} < DEPTH_L;
  assign r_bank_a = bus.R0_addr >> BANK_AW;
  assign w_bank_a = bus.W0_addr >> BANK_AW;
  assign r_maddr  = BANK_AW'(bus.R0_addr);
  assign w_maddr  = BANK_AW'(bus.W0_addr);
  assign collide  = bus.R0_en && bus.W0_en && r_inr && (bus.R0_addr == bus.W0_addr);

  // Expand lane mask to a per-bit mask.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < NLANES; i++) w_bmask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{bus.W0_mask[i]}};
  end

  // Unused high bits of the last slice are written as zero.
  assign w_bmask_pad = PADW'(w_bmask);
  assign w_data_pad  = PADW'(bus.W0_data);

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    for (genvar s = 0; s < NSLICES; s++) begin : g_slice
      logic rd_ce_n, wr_ce_n;
      assign rd_ce_n = !(bus.R0_en && r_inr && (r_bank_a == ADDR_W'(b)));
      assign wr_ce_n = !(bus.W0_en && w_inr && (w_bank_a == ADDR_W'(b)) &&
                         (|w_bmask_pad[s*MACRO_WIDTH +: MACRO_WIDTH]));
      rf_2p_macro #(.AW(BANK_AW), .DW(MACRO_WIDTH)) u_macro (
        .clk      (clk),
        .rd_ce_n  (rd_ce_n),
        .rd_addr  (r_maddr),
        .rd_q     (macro_q[b][s]),
        .wr_ce_n  (wr_ce_n),
        .wr_addr  (w_maddr),
        .wr_data  (w_data_pad[s*MACRO_WIDTH +: MACRO_WIDTH]),
        .wr_bmask (w_bmask_pad[s*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  // Select the bank registered with the read.
  always_comb begin
    rd_sel = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (r_bank_q == BIDX_W'(b)) begin
        for (int s = 0; s < NSLICES; s++) rd_sel[s*MACRO_WIDTH +: MACRO_WIDTH] = macro_q[b][s];
      end
    end
  end

  // Overlay forwarded write lanes on the old macro data; out-of-range reads return zero.
  always_comb begin
    rd_merged = '0;
    if (r_inr_q) rd_merged = (rd_sel[WIDTH-1:0] & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);
  end

  // Read pipeline: bank index, range bit and collision forwarding captured per accepted read.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      r_bank_q   <= '0;
      r_inr_q    <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else begin
      rd_pend_q <= bus.R0_en;
      if (bus.R0_en) begin
        r_bank_q   <= BIDX_W'(r_bank_a);
        r_inr_q    <= r_inr;
        fwd_data_q <= bus.W0_data;
        fwd_mask_q <= collide ? w_bmask : '0;
      end
    end
  end

  // Hold register keeps the last returned word while no read is returning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         data_hold_q <= '0;
    else if (rd_pend_q) data_hold_q <= rd_merged;
  end

  // Sticky out-of-range flag for any enabled access beyond DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oor_q <= 1'b0;
    else if ((bus.R0_en && !r_inr) || (bus.W0_en && !w_inr)) oor_q <= 1'b1;
  end

  assign bus.R0_data  = rd_pend_q ? rd_merged : data_hold_q;
  assign bus.R0_valid = rd_pend_q;
  assign bus.oor_flag = oor_q;
endmodule

// File: tb/tb_mem_1r1w_banked.sv
// Self-checking bench for mem_1r1w_banked: directed vector table, reset and
// hold sequences, and randomized traffic against a word-level memory model.
module tb_mem_1r1w_banked;
  localparam int DEPTH = 48;
  localparam int WIDTH = 64;
  localparam int AW    = 6;
  localparam int NL    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_1r1w_banked_if #(.ADDR_W(AW), .WIDTH(WIDTH), .NLANES(NL)) bus ();

  mem_1r1w_banked #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .BANK_DEPTH(32), .MACRO_WIDTH(16), .MASK_GRAN(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] ref_mem [64];
  logic [WIDTH-1:0] last_data;
  logic             exp_oor;

  typedef struct {
    logic             ren;
    logic [AW-1:0]    raddr;
    logic             wen;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [NL-1:0]    wmask;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] lane_bits(input logic [NL-1:0] m);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*16 +: 16] = {16{m[i]}};
    return r;
  endfunction

  // One clock cycle of traffic; the model applies write-first word semantics.
  task automatic cycle(input logic ren, input logic [AW-1:0] raddr, input logic wen,
                       input logic [AW-1:0] waddr, input logic [WIDTH-1:0] wdata,
                       input logic [NL-1:0] wmask);
    logic [WIDTH-1:0] bm, exp_d;
    bm = lane_bits(wmask);
    bus.R0_en = ren;  bus.R0_addr = raddr;
    bus.W0_en = wen;  bus.W0_addr = waddr;  bus.W0_data = wdata;  bus.W0_mask = wmask;
    exp_d = '0;
    if (raddr < DEPTH) begin
      exp_d = ref_mem[raddr];
      if (wen && waddr == raddr) exp_d = (exp_d & ~bm) | (wdata & bm);
    end
    if (wen && waddr < DEPTH) ref_mem[waddr] = (ref_mem[waddr] & ~bm) | (wdata & bm);
    if ((ren && raddr >= DEPTH) || (wen && waddr >= DEPTH)) exp_oor = 1'b1;
    if (ren) last_data = exp_d;
    @(posedge clk);
    #1;
    check("r0_valid", 64'(bus.R0_valid), 64'(ren));
    check("r0_data", bus.R0_data, last_data);
    check("oor_flag", 64'(bus.oor_flag), 64'(exp_oor));
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.R0_en = 1'b0; bus.R0_addr = '0;
    bus.W0_en = 1'b0; bus.W0_addr = '0; bus.W0_data = '0; bus.W0_mask = '0;
    last_data = '0;
    exp_oor   = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(bus.R0_valid), 64'd0);
    check("reset_data", bus.R0_data, 64'd0);
    check("reset_oor", 64'(bus.oor_flag), 64'd0);
    rst_n = 1'b1;

    // Give every word a known value before reading.
    for (int a = 0; a < DEPTH; a++)
      cycle(1'b0, '0, 1'b1, AW'(a), {$urandom, $urandom}, 4'hF);

    vecs[0]  = '{1'b0, 6'd0,  1'b1, 6'd5,  64'h1111_2222_3333_4444, 4'hF, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 6'd5,  1'b0, 6'd0,  64'h0,                   4'h0, 1'b1, 64'h1111_2222_3333_4444};
    vecs[2]  = '{1'b0, 6'd0,  1'b1, 6'd31, 64'hAAAA_AAAA_AAAA_AAAA, 4'hF, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 6'd0,  1'b1, 6'd32, 64'h5555_5555_5555_5555, 4'hF, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 6'd0,  1'b1, 6'd47, 64'hDEAD_BEEF_0000_0001, 4'hF, 1'b0, 64'h0};
    vecs[5]  = '{1'b1, 6'd31, 1'b0, 6'd0,  64'h0,                   4'h0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[6]  = '{1'b1, 6'd32, 1'b0, 6'd0,  64'h0,                   4'h0, 1'b1, 64'h5555_5555_5555_5555};
    vecs[7]  = '{1'b1, 6'd47, 1'b0, 6'd0,  64'h0,                   4'h0, 1'b1, 64'hDEAD_BEEF_0000_0001};
    vecs[8]  = '{1'b0, 6'd0,  1'b1, 6'd7,  64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 6'd0,  1'b1, 6'd7,  64'h0,                   4'h5, 1'b0, 64'h0};
    vecs[10] = '{1'b1, 6'd7,  1'b0, 6'd0,  64'h0,                   4'h0, 1'b1, 64'hFFFF_0000_FFFF_0000};
    vecs[11] = '{1'b0, 6'd0,  1'b1, 6'd9,  64'h0123_4567_89AB_CDEF, 4'hF, 1'b0, 64'h0};
    vecs[12] = '{1'b1, 6'd9,  1'b1, 6'd9,  64'h0,                   4'h8, 1'b1, 64'h0000_4567_89AB_CDEF};
    vecs[13] = '{1'b1, 6'd9,  1'b0, 6'd0,  64'h0,                   4'h0, 1'b1, 64'h0000_4567_89AB_CDEF};
    vecs[14] = '{1'b1, 6'd9,  1'b1, 6'd9,  64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 1'b1, 64'h0000_4567_89AB_CDEF};
    vecs[15] = '{1'b0, 6'd0,  1'b1, 6'd18, 64'h1818_1818_1818_1818, 4'hF, 1'b0, 64'h0};
    vecs[16] = '{1'b0, 6'd0,  1'b1, 6'd50, 64'hBAD0_BAD0_BAD0_BAD0, 4'hF, 1'b0, 64'h0};
    vecs[17] = '{1'b1, 6'd50, 1'b0, 6'd0,  64'h0,                   4'h0, 1'b1, 64'h0};
    vecs[18] = '{1'b1, 6'd18, 1'b0, 6'd0,  64'h0,                   4'h0, 1'b1, 64'h1818_1818_1818_1818};
    vecs[19] = '{1'b1, 6'd0,  1'b1, 6'd47, 64'h7777_7777_7777_7777, 4'hF, 1'b1, 64'h0};
    vecs[19].exp_data = ref_mem[0];

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].ren, vecs[i].raddr, vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].wmask);
      check($sformatf("vec%0d_valid", i), 64'(bus.R0_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), bus.R0_data, vecs[i].exp_data);
    end

    // Hold: read a word, then five idle cycles must keep the data and drop valid.
    cycle(1'b1, 6'd31, 1'b0, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("hold_data", bus.R0_data, 64'hAAAA_AAAA_AAAA_AAAA);
    end

    // Reset asserted while a read return is on the output.
    cycle(1'b1, 6'd5, 1'b0, '0, '0, '0);
    bus.R0_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(bus.R0_valid), 64'd0);
    check("rst_mid_data", bus.R0_data, 64'd0);
    check("rst_mid_oor", 64'(bus.oor_flag), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_data = '0;
    exp_oor   = 1'b0;
    idle();
    // Contents survive reset.
    cycle(1'b1, 6'd32, 1'b0, '0, '0, '0);
    check("post_rst_data", bus.R0_data, 64'h5555_5555_5555_5555);

    // Randomized traffic with frequent same-address collisions.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] ra, wa;
      ra = AW'($urandom_range(0, 55));
      wa = ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, 55));
      cycle(1'($urandom), ra, 1'($urandom), wa, {$urandom, $urandom}, NL'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_1r1w_banked.md
Name: mem_1r1w_banked

Overview:
Parametrised one-read/one-write synchronous memory on a single clock. It tiles two-port register-file macros into banks (depth) and slices (width). It adds what a plain lowered wrapper lacks: per-lane write masks, read-during-write forwarding, a read-data hold register, a read-valid strobe, and out-of-range detection. It is the drop-in lowering target for Chisel 1r1w memories that need defined collision semantics.

Parameters:
DEPTH, 48, number of words; need not be a multiple of BANK_DEPTH.
WIDTH, 64, word width in bits.
BANK_DEPTH, 32, words per macro (power of 2).
MACRO_WIDTH, 16, data bits per macro.
MASK_GRAN, 16, bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN.
ADDR_W, clog2(DEPTH), address width (derived).
NLANES, WIDTH/MASK_GRAN, mask width (derived).

Ports:
clk  in  1  single clock for both ports.
rst_n  in  1  asynchronous active-low reset.
R0_addr  in  ADDR_W  read address.
R0_en  in  1  read enable.
R0_data  out  WIDTH  read data, valid the cycle after the accepted read, then held.
R0_valid  out  1  one-cycle pulse, asserted the cycle after R0_en=1.
W0_addr  in  ADDR_W  write address.
W0_en  in  1  write enable.
W0_data  in  WIDTH  write data.
W0_mask  in  NLANES  per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].
oor_flag  out  1  sticky flag, set by any enabled access with address >= DEPTH.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: R0_data=0, R0_valid=0, oor_flag=0. Internal bank-index and forward registers also clear. Memory contents are not reset.
- Tiling:
  - NBANKS = ceil(DEPTH/BANK_DEPTH); NSLICES = ceil(WIDTH/MACRO_WIDTH).
  - Bank select = addr >> clog2(BANK_DEPTH). The macro receives the low clog2(BANK_DEPTH) address bits.
  - Unused high data bits of the last slice: write inputs are tied to 0 and read outputs are ignored.
  - Each macro has active-low chip enables.
- Macro chip enables:
  - Read: enabled only when R0_en and the bank matches and addr < DEPTH.
  - Write: enabled only when W0_en and the bank matches and addr < DEPTH and the slice contains at least one asserted mask lane. Per-bit write masking is applied within the macro.
- Read latency is 1 cycle. On a clk edge with R0_en=1, the block registers the bank index, an in-range bit, and collision info. Next cycle: R0_data = muxed macro output, R0_valid=1.
- Hold: when R0_en=0, R0_data keeps its last value and R0_valid=0. The output register updates only on a valid return.
- Out of range:
  - Read with addr >= DEPTH: returns all-zero data with R0_valid=1, and sets oor_flag.
  - Write with addr >= DEPTH: dropped, and sets oor_flag.
  - oor_flag clears only on reset.
- Read-during-write collision, defined as same cycle, R0_en and W0_en, R0_addr==W0_addr, in range:
  - The macro returns old contents.
  - The block registers W0_data and W0_mask.
  - Next cycle, R0_data lanes with mask=1 come from the forwarded write data; lanes with mask=0 come from the macro (old data).
  - Net effect: write-first semantics.
- A write with mask=0 and W0_en=1: no macro write, no forwarding effect (old data returned).
- Back-to-back reads: fully pipelined, one read accepted per cycle.
- Reset asserted mid-read: R0_valid and R0_data return to 0 immediately; the pending return is discarded.

Test Plan:
1. Reset, then write 0x1111_2222_3333_4444 to addr 5 (mask=4'hF); next cycle read addr 5 -> R0_valid pulses 1 cycle later, R0_data=0x1111_2222_3333_4444.
2. Bank crossing: write addr 31=0xAAAA…, addr 32=0x5555…, addr 47=0xDEAD_BEEF_0000_0001; read 31, 32, 47 back-to-back -> three consecutive valid cycles with the matching data.
3. Mask: addr 7 holds 0xFFFF_FFFF_FFFF_FFFF; write 0 with mask=4'b0101 -> read returns 0xFFFF_0000_FFFF_0000.
4. Collision: addr 9 holds 0x0123_4567_89AB_CDEF; same cycle write 0 with mask=4'b1000 and read addr 9 -> R0_data=0x0000_4567_89AB_CDEF.
5. Out of range: write addr 50 then read addr 50 -> read data 0, R0_valid=1, oor_flag=1 and stays 1. Addr 50 is not aliased: addr 18 is unchanged.
6. Hold/reset: after a read returns X, keep R0_en=0 for 5 cycles -> R0_data=X and R0_valid=0. Assert rst_n=0 in the cycle after a read issue -> R0_data=0, R0_valid=0 asynchronously.
